par2ser_stream: RTL and testbench
=================================

Name: par2ser_stream

Overview:
Parametrised parallel-to-serial converter with valid/ready handshakes on both sides.
- Accepts DATA_W-bit words of programmable length (1..DATA_W bits) and emits them one bit per accepted beat, LSB- or MSB-first.
- A one-entry holding register lets the next word be accepted while the current one shifts, giving gapless back-to-back output.
- Sits between a word-oriented producer (register block / FIFO) and a bit-serial link driver that can stall.

Parameters:
DATA_W, 8, width of parallel word; legal 2..64
MSB_FIRST, 0, 0 = bit 0 first, 1 = bit len-1 first
CNT_W, $clog2(DATA_W+1), width of length field and bit counter (derived, not overridden)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
in_valid_i  input  1  parallel word offered
in_ready_o  output  1  block can take a word this cycle
in_data_i  input  DATA_W  parallel word; bits above len ignored
in_len_i  input  CNT_W  number of bits to send; 0 means DATA_W; values >DATA_W clamp to DATA_W
out_valid_o  output  1  serial bit valid
out_ready_i  input  1  sink accepts bit
out_data_o  output  1  serial bit
out_last_o  output  1  current bit is final bit of its word
empty_o  output  1  no word held or in flight

Behaviour:
- Reset values: in_ready_o=1, out_valid_o=0, out_data_o=0, out_last_o=0, empty_o=1; shifter, counter, holding register cleared. Reset mid-word discards shifter and holding contents; no partial word resumes.
- State: shift stage (shift_q, rem_q = bits remaining, active = rem_q!=0); holding stage (hold_data_q, hold_len_q, hold_vld_q).
- in_ready_o = ~hold_vld_q (registered-state only; no combinational path from out_ready_i).
- Input accept = in_valid_i & in_ready_o. Output beat = out_valid_o & out_ready_i.
- Shifter "free" this cycle = ~active | (beat & rem_q==1).
- Load priority at each edge: if free and hold_vld_q, shifter loads from hold; if free and hold empty and accept, incoming word bypasses hold straight into shifter; otherwise accepted word goes to hold. Accept and hold-to-shifter transfer in the same cycle: hold is refilled with the incoming word.
- Latency: word accepted into an idle block at edge T drives out_valid_o=1 with its first bit in cycle T+1.
- Gapless: with out_ready_i=1 and a word in hold, the first bit of the next word follows the last bit of the current word in the next cycle.
- On beat: rem_q decrements; shift_q shifts right (MSB_FIRST=0) or left (MSB_FIRST=1). Unused bits shift in as 0.
- out_data_o = shift_q[0] (MSB_FIRST=0) or shift_q[len-1] of the loaded word (MSB_FIRST=1). Implementation left-aligns the word at load so the output tap is shift_q[DATA_W-1].
- out_valid_o = active. out_last_o = active & rem_q==1.
- Stall rule: while out_valid_o=1 and out_ready_i=0, out_data_o and out_last_o hold stable.
- empty_o = ~active & ~hold_vld_q, derived from registered state only.
- Maximum occupancy is two words. The third word is refused (in_ready_o=0) until the shifter frees.
- Length 1 word: out_last_o=1 on its only bit.

Decomposition:
- Shared package par2ser_pkg: function clamp_len (0 or >DATA_W maps to DATA_W), typedef for a {data, len} word record.
- One natural sub-module, par2ser_hold: one-entry holding register with valid/ready, bypass and refill-on-drain behaviour.
- Shifter and counter stay in the top level.

Test Plan:
- Single word, DATA_W=8, MSB_FIRST=0, in_data=8'hA5, len=0, out_ready=1 -> bits 1,0,1,0,0,1,0,1 on cycles T+1..T+8; out_last only on cycle T+8; empty_o=1 from T+9.
- MSB_FIRST=1, in_data=8'h0B, len=4 -> bits 1,0,1,1; out_last on the 4th bit; bits 7..4 never emitted.
- Back-to-back 8'hFF then 8'h00, in_valid held, out_ready=1 -> 16 consecutive valid beats with no gap. in_ready_o=0 after the second accept until the first word's last beat.
- Backpressure: out_ready toggles 1,0,0,1… during word 8'h3C -> data/last stable while stalled; the sequence still matches 0,0,1,1,1,1,0,0.
- Third word offered while shifter active and hold full -> in_ready_o=0, word not taken; accepted in the cycle after the shifter loads from hold.
- Assert reset for 1 cycle after the 3rd bit of a word with a second word in hold -> next cycle out_valid_o=0, empty_o=1, in_ready_o=1; no residual bits emitted afterwards.

Source files
------------

// File: rtl/par2ser_pkg.sv
// ============================================================================
// par2ser_pkg : shared types and length clamp for the par2ser_stream block
// Revision    : 1.0
// ============================================================================
`default_nettype none

package par2ser_pkg;

  localparam int unsigned MAX_DATA_W = 64;
  localparam int unsigned MAX_LEN_W  = 7;

  // Widest possible {data, len} record; instances narrow it to their own widths.
  typedef struct packed {
    logic [MAX_DATA_W-1:0] data;
    logic [MAX_LEN_W-1:0]  len;
  } word_t;

  // A length of 0, or anything past the word width, means "the whole word".
  function automatic logic [MAX_LEN_W-1:0] clamp_len(
    input logic [MAX_LEN_W-1:0] len,
    input logic [MAX_LEN_W-1:0] data_w
  );
    if ((len == '0) || (len > data_w)) begin
      return data_w;
    end
    return len;
  endfunction

endpackage

`default_nettype wire

// File: rtl/par2ser_hold.sv
// ============================================================================
// par2ser_hold : one-entry holding register with bypass and refill-on-drain
// Revision     : 1.0
// ============================================================================
`default_nettype none

module par2ser_hold #(
  parameter type WORD_T = par2ser_pkg::word_t
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  in_valid,
  output logic  in_ready,
  input  WORD_T in_word,
  input  logic  take,
  output logic  out_valid,
  output WORD_T out_word
);

  logic  hold_vld_q;
  WORD_T hold_q;

  logic accept;
  logic bypass;
  logic to_hold;
  logic drain;

  assign in_ready = ~hold_vld_q;
  assign accept   = in_valid & in_ready;
  assign drain    = take & hold_vld_q;
  assign bypass   = take & ~hold_vld_q & accept;
  assign to_hold  = accept & ~bypass;

  // The held word always outranks a newly offered one.
  assign out_valid = hold_vld_q | accept;
  assign out_word  = hold_vld_q ? hold_q : in_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      if (to_hold) begin
        hold_vld_q <= 1'b1;
        hold_q     <= in_word;
      end else if (drain) begin
        hold_vld_q <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/par2ser_stream.sv
// ============================================================================
// par2ser_stream : parallel-to-serial converter with valid/ready on both sides
// Revision       : 1.0
// ============================================================================
`default_nettype none

module par2ser_stream
  import par2ser_pkg::*;
#(
  parameter  int DATA_W    = 8,
  parameter  bit MSB_FIRST = 1'b0,
  localparam int CNT_W     = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CNT_W-1:0]  in_len_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_data_o,
  output logic              out_last_o,
  output logic              empty_o
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  len;
  } rec_t;

  rec_t              in_rec;
  rec_t              ld_rec;
  logic              ld_valid;

  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  rem_q;

  logic              active;
  logic              beat;
  logic              free;
  logic              load;
  logic              rem_one;

  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] ld_shift;
  logic [DATA_W-1:0] shift_nxt;
  logic              tap;

  assign in_rec.data = in_data_i;
  assign in_rec.len  = CNT_W'(clamp_len(MAX_LEN_W'(in_len_i), MAX_LEN_W'(DATA_W)));

  par2ser_hold #(
    .WORD_T (rec_t)
  ) u_hold (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid_i),
    .in_ready  (in_ready_o),
    .in_word   (in_rec),
    .take      (free),
    .out_valid (ld_valid),
    .out_word  (ld_rec)
  );

  assign active  = (rem_q != '0);
  assign rem_one = (rem_q == CNT_W'(1));
  assign beat    = active & out_ready_i;
  assign free    = ~active | (beat & rem_one);
  assign load    = free & ld_valid;

  // Bits above len are cleared so nothing stale ever reaches the tap.
  always_comb begin
    mask = {DATA_W{1'b1}} >> (DATA_W - int'(ld_rec.len));
    ld_shift = ld_rec.data & mask;
  end

  generate
    if (MSB_FIRST) begin : g_msb_first
      logic [DATA_W-1:0] aligned;
      // Left-align so bit len-1 sits on the top tap.
      assign aligned   = ld_shift << (DATA_W - int'(ld_rec.len));
      assign shift_nxt = shift_q << 1;
      assign tap       = shift_q[DATA_W-1];

      always_ff @(posedge clk) begin
        if (reset) begin
          shift_q <= '0;
        end else if (load) begin
          shift_q <= aligned;
        end else if (beat) begin
          shift_q <= shift_nxt;
        end
      end
    end else begin : g_lsb_first
      assign shift_nxt = shift_q >> 1;
      assign tap       = shift_q[0];

      always_ff @(posedge clk) begin
        if (reset) begin
          shift_q <= '0;
        end else if (load) begin
          shift_q <= ld_shift;
        end else if (beat) begin
          shift_q <= shift_nxt;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
    end else if (load) begin
      rem_q <= ld_rec.len;
    end else if (beat) begin
      rem_q <= rem_q - CNT_W'(1);
    end
  end

  assign out_valid_o = active;
  assign out_data_o  = tap;
  assign out_last_o  = active & rem_one;
  assign empty_o     = ~active & in_ready_o;

endmodule

`default_nettype wire

// File: tb/tb_par2ser_stream.sv
// ============================================================================
// tb_par2ser_stream : directed bench for par2ser_stream (LSB- and MSB-first)
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_par2ser_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic [3:0] in_len;
  logic       out_ready;

  logic in_ready0, out_valid0, out_data0, out_last0, empty0;
  logic in_ready1, out_valid1, out_data1, out_last1, empty1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  par2ser_stream #(.DATA_W(8), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .in_data_i(in_data), .in_len_i(in_len),
    .out_valid_o(out_valid0), .out_ready_i(out_ready),
    .out_data_o(out_data0), .out_last_o(out_last0), .empty_o(empty0)
  );

  par2ser_stream #(.DATA_W(8), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .in_data_i(in_data), .in_len_i(in_len),
    .out_valid_o(out_valid1), .out_ready_i(out_ready),
    .out_data_o(out_data1), .out_last_o(out_last1), .empty_o(empty1)
  );

  typedef struct {
    string      name;
    logic [7:0] data;
    logic [3:0] len;
    bit         msb;
    logic [7:0] exp_bits;  // bit i = i-th serial bit emitted
    int         n;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic pick(input bit msb, input logic a0, input logic a1);
    return msb ? a1 : a0;
  endfunction

  task automatic run_vec(input vec_t v);
    int         guard;
    int         nb;
    logic [7:0] got;
    logic [7:0] lastm;
    guard = 0;
    while (!in_ready0 && guard < 20) begin
      tick();
      guard++;
    end
    in_valid  = 1'b1;
    in_data   = v.data;
    in_len    = v.len;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({v.name, "_latency"}, 32'(pick(v.msb, out_valid0, out_valid1)), 32'd1);
    nb = 0; got = '0; lastm = '0; guard = 0;
    while (nb < v.n && guard < 40) begin
      if (pick(v.msb, out_valid0, out_valid1)) begin
        got[nb]   = pick(v.msb, out_data0, out_data1);
        lastm[nb] = pick(v.msb, out_last0, out_last1);
        nb++;
      end
      tick();
      guard++;
    end
    check({v.name, "_count"}, 32'(nb), 32'(v.n));
    check({v.name, "_bits"}, 32'(got), 32'(v.exp_bits));
    check({v.name, "_last"}, 32'(lastm), 32'(8'd1 << (v.n - 1)));
    check({v.name, "_empty"}, 32'(pick(v.msb, empty0, empty1)), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [15:0] bits16, last16, rdy16;
    logic [23:0] stream;
    logic [7:0]  e;
    int          vcnt, nb, guard, c, acc_k;
    int          pat[4];

    vecs[0] = '{"lsb_a5_len0",  8'hA5, 4'd0,  1'b0, 8'hA5, 8};
    vecs[1] = '{"msb_0b_len4",  8'h0B, 4'd4,  1'b1, 8'h0D, 4};
    vecs[2] = '{"lsb_3c_len8",  8'h3C, 4'd8,  1'b0, 8'h3C, 8};
    vecs[3] = '{"lsb_fe_len1",  8'hFE, 4'd1,  1'b0, 8'h00, 1};
    vecs[4] = '{"msb_01_len1",  8'h01, 4'd1,  1'b1, 8'h01, 1};
    vecs[5] = '{"lsb_81_len12", 8'h81, 4'd12, 1'b0, 8'h81, 8};
    vecs[6] = '{"msb_c1_len0",  8'hC1, 4'd0,  1'b1, 8'h83, 8};
    vecs[7] = '{"lsb_f6_len3",  8'hF6, 4'd3,  1'b0, 8'h06, 3};
    vecs[8] = '{"msb_e9_len5",  8'hE9, 4'd5,  1'b1, 8'h12, 5};
    pat = '{1, 0, 0, 1};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; in_len = '0; out_ready = 1'b1;
    tick(); tick();
    check("rst_in_ready",  32'(in_ready0),  32'd1);
    check("rst_out_valid", 32'(out_valid0), 32'd0);
    check("rst_out_data",  32'(out_data0),  32'd0);
    check("rst_out_last",  32'(out_last0),  32'd0);
    check("rst_empty",     32'(empty0),     32'd1);
    check("rst_msb_valid", 32'(out_valid1), 32'd0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back FF then 00 with in_valid held for two accepts.
    in_valid = 1'b1; in_data = 8'hFF; in_len = 4'd0; out_ready = 1'b1;
    tick();
    in_data = 8'h00;
    bits16 = '0; last16 = '0; rdy16 = '0; vcnt = 0;
    for (int k = 0; k < 16; k++) begin
      bits16[k] = out_data0;
      last16[k] = out_last0;
      rdy16[k]  = in_ready0;
      if (out_valid0) vcnt++;
      tick();
      if (k == 0) in_valid = 1'b0;
    end
    check("b2b_valid_beats", 32'(vcnt),   32'd16);
    check("b2b_bits",        32'(bits16), 32'h00FF);
    check("b2b_last",        32'(last16), 32'h8080);
    check("b2b_in_ready",    32'(rdy16),  32'hFF01);
    check("b2b_empty",       32'(empty0), 32'd1);

    // Backpressure on 3C: every displayed bit must match the next expected bit.
    e = 8'h3C;
    in_valid = 1'b1; in_data = 8'h3C; in_len = 4'd0;
    tick();
    in_valid = 1'b0;
    nb = 0; guard = 0; c = 0;
    while (nb < 8 && guard < 40) begin
      out_ready = pat[c % 4][0];
      if (out_valid0) begin
        check("bp_data", 32'(out_data0), 32'(e[nb]));
        check("bp_last", 32'(out_last0), 32'(nb == 7));
        if (out_ready) nb++;
      end
      tick();
      c++;
      guard++;
    end
    out_ready = 1'b1;
    check("bp_count", 32'(nb), 32'd8);
    check("bp_empty", 32'(empty0), 32'd1);

    // Third word offered while shifter busy and hold full.
    in_valid = 1'b1; in_data = 8'h55; in_len = 4'd0;
    tick();
    stream = '0; nb = 0; acc_k = -1;
    for (int k = 0; k < 60 && nb < 24; k++) begin
      if (out_valid0) begin
        stream[nb] = out_data0;
        nb++;
      end
      if (k == 0) begin
        in_data = 8'h0F;
      end else if (k == 1) begin
        in_data = 8'hC3;
        check("w3_hold_full", 32'(in_ready0), 32'd0);
      end else if (acc_k < 0 && in_ready0) begin
        acc_k = k;
      end else if (acc_k >= 0 && k == acc_k + 1) begin
        in_valid = 1'b0;
        check("w3_refused_again", 32'(in_ready0), 32'd0);
      end
      tick();
    end
    in_valid = 1'b0;
    check("w3_accept_cycle", 32'(acc_k), 32'd8);
    check("w3_stream", 32'(stream), 32'hC30F55);
    check("w3_empty", 32'(empty0), 32'd1);

    // Reset mid-word with a second word in hold.
    in_valid = 1'b1; in_data = 8'hFF; in_len = 4'd0;
    tick();
    in_data = 8'hF0;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_out_valid", 32'(out_valid0), 32'd0);
    check("mrst_empty",     32'(empty0),     32'd1);
    check("mrst_in_ready",  32'(in_ready0),  32'd1);
    check("mrst_out_data",  32'(out_data0),  32'd0);
    check("mrst_out_last",  32'(out_last0),  32'd0);
    check("mrst_msb_empty", 32'(empty1),     32'd1);
    vcnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid0 || out_valid1) vcnt++;
      tick();
    end
    check("mrst_no_residual", 32'(vcnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
